// File: rtl/bram_traffic_seq.sv
// Write/read traffic sequencer and checker for one bram instance: fills every address with
// pat(a) = SEED ^ a, then streams back-to-back reads and counts words that come back wrong.
module bram_traffic_seq #(
    parameter int unsigned A_WID  = 11,
    parameter int unsigned D_WID  = 16,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned SWEEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic [A_WID-1:0] wraddr,
    output logic [D_WID-1:0] din,
    output logic             we,
    output logic             porta_en,
    output logic [A_WID-1:0] rdaddr,
    output logic             portb_en,
    input  logic [D_WID-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      err_cnt,
    output logic [A_WID-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [D_WID-1:0] SEED_D    = D_WID'(SEED);
    localparam logic [A_WID-1:0] LAST_ADDR = '1;
    localparam bit               FINITE    = (SWEEPS != 0);
    localparam logic [31:0]      LAST_PASS = FINITE ? 32'(SWEEPS - 1) : 32'd0;

    state_t           state_reg;
    logic [31:0]      pass_cnt_reg;
    logic             drain_cnt_reg;
    logic [A_WID-1:0] rd_q_reg;
    logic             chk_vld_reg;
    logic             mismatch;
    logic             last_read;

    function automatic logic [D_WID-1:0] pat(input logic [A_WID-1:0] a);
        return SEED_D ^ D_WID'(a);
    endfunction

    // rd_q_reg tracks the bram's internal read-address register, so dout lines up with it.
    assign mismatch  = chk_vld_reg && (dout != pat(rd_q_reg));
    assign last_read = FINITE && (rdaddr == LAST_ADDR) && (pass_cnt_reg == LAST_PASS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pass_cnt_reg   <= '0;
            drain_cnt_reg  <= 1'b0;
            rd_q_reg       <= '0;
            chk_vld_reg    <= 1'b0;
            wraddr         <= '0;
            din            <= '0;
            we             <= 1'b0;
            porta_en       <= 1'b0;
            rdaddr         <= '0;
            portb_en       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            rd_q_reg    <= rdaddr;
            chk_vld_reg <= portb_en;

            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                if (!err)
                    first_err_addr <= rd_q_reg;
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg      <= ST_FILL;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        we             <= 1'b1;
                        porta_en       <= 1'b1;
                        wraddr         <= '0;
                        din            <= pat('0);
                        err            <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                ST_FILL: begin
                    if (wraddr == LAST_ADDR) begin
                        state_reg    <= ST_SWEEP;
                        we           <= 1'b0;
                        porta_en     <= 1'b0;
                        portb_en     <= 1'b1;
                        rdaddr       <= '0;
                        pass_cnt_reg <= '0;
                    end else begin
                        wraddr <= wraddr + 1'b1;
                        din    <= pat(wraddr + 1'b1);
                    end
                end
                ST_SWEEP: begin
                    // The address currently on rdaddr is the final one when leaving.
                    if (stop || last_read) begin
                        state_reg     <= ST_DRAIN;
                        portb_en      <= 1'b0;
                        drain_cnt_reg <= 1'b0;
                    end else begin
                        rdaddr <= rdaddr + 1'b1;
                        if (rdaddr == LAST_ADDR)
                            pass_cnt_reg <= pass_cnt_reg + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_traffic_seq.sv
// Scoreboard bench: two sequencers (SWEEPS=2 and SWEEPS=0), each beside a registered-read bram model.
module tb_bram_traffic_seq;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic        e;
        logic [15:0] cnt;
        logic [3:0]  fa;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0_a = 0;
    int   t0_b = 0;

    logic        start_a = 0, stop_a = 0, fault_a = 0;
    logic [3:0]  wraddr_a, rdaddr_a, first_err_addr_a;
    logic [15:0] din_a, dout_a, err_cnt_a;
    logic        we_a, porta_en_a, portb_en_a, busy_a, done_a, err_a;

    logic        start_b = 0, stop_b = 0, corrupt_b = 0;
    logic [3:0]  wraddr_b, rdaddr_b, first_err_addr_b;
    logic [15:0] din_b, dout_b, err_cnt_b;
    logic        we_b, porta_en_b, portb_en_b, busy_b, done_b, err_b;

    logic [19:0] wq_a[$], wq_b[$];
    logic [3:0]  rq_a[$], rq_b[$];
    res_t        dq_a[$], dq_b[$];
    logic        done_prev_a = 0, done_prev_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    bram_traffic_seq #(.A_WID(4), .D_WID(16), .SEED(SEED), .SWEEPS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .wraddr(wraddr_a), .din(din_a), .we(we_a), .porta_en(porta_en_a),
        .rdaddr(rdaddr_a), .portb_en(portb_en_a), .dout(dout_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_cnt(err_cnt_a),
        .first_err_addr(first_err_addr_a)
    );

    bram_traffic_seq #(.A_WID(4), .D_WID(16), .SEED(SEED), .SWEEPS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .wraddr(wraddr_b), .din(din_b), .we(we_b), .porta_en(porta_en_b),
        .rdaddr(rdaddr_b), .portb_en(portb_en_b), .dout(dout_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b),
        .first_err_addr(first_err_addr_b)
    );

    // bram models: registered read address, combinational data from it
    logic [15:0] mem_a [0:15];
    logic [15:0] mem_b [0:15];
    logic [3:0]  rdq_a = 0, rdq_b = 0;

    always @(posedge clk) begin
        if (we_a && porta_en_a) mem_a[wraddr_a] <= din_a;
        if (portb_en_a) rdq_a <= rdaddr_a;
        if (we_b && porta_en_b) mem_b[wraddr_b] <= din_b;
        if (portb_en_b) rdq_b <= rdaddr_b;
    end

    assign dout_a = mem_a[rdq_a] ^ ((fault_a && rdq_a == 4'd5) ? 16'h0001 : 16'h0000);
    assign dout_b = mem_b[rdq_b] ^ (corrupt_b ? 16'h0001 : 16'h0000);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_run(input bit sel, input int nreads, input logic e,
                              input logic [15:0] cnt, input logic [3:0] fa, input int lat);
        res_t r;
        for (int a = 0; a < 16; a++) begin
            logic [3:0] a4;
            a4 = 4'(a);
            if (sel) wq_b.push_back({a4, SEED ^ {12'h000, a4}});
            else     wq_a.push_back({a4, SEED ^ {12'h000, a4}});
        end
        for (int i = 0; i < nreads; i++) begin
            if (sel) rq_b.push_back(4'(i));
            else     rq_a.push_back(4'(i));
        end
        r.e = e; r.cnt = cnt; r.fa = fa; r.lat = lat;
        if (sel) dq_b.push_back(r);
        else     dq_a.push_back(r);
        $display("run %s: expect %0d reads err=%0d err_cnt=%0h first=%0d done_edge=%0d",
                 sel ? "B" : "A", nreads, e, cnt, fa, lat);
    endtask

    task automatic start_pulse(input bit sel, input logic with_stop);
        @(negedge clk);
        if (sel) begin start_b = 1; stop_b = with_stop; end
        else     begin start_a = 1; stop_a = with_stop; end
        @(posedge clk);
        #1;
        start_a = 0; stop_a = 0; start_b = 0; stop_b = 0;
        if (sel) t0_b = edge_cnt;
        else     t0_a = edge_cnt;
    endtask

    task automatic wait_done(input bit sel, input int limit);
        logic d;
        d = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            d = sel ? done_b : done_a;
            if (d) break;
        end
        chk(sel ? "done_seen_b" : "done_seen_a", 64'(d), 64'd1);
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                if (wq_a.size() == 0) chk("wr_a_unexpected", 64'(wraddr_a), 64'hFFFF);
                else chk("wr_a", 64'({wraddr_a, din_a}), 64'(wq_a.pop_front()));
            end
            if (portb_en_a) begin
                if (rq_a.size() == 0) chk("rd_a_unexpected", 64'(rdaddr_a), 64'hFFFF);
                else chk("rd_a", 64'(rdaddr_a), 64'(rq_a.pop_front()));
            end
            if (done_a && !done_prev_a) begin
                if (dq_a.size() == 0) chk("done_a_unexpected", 64'(done_a), 64'd0);
                else begin
                    res_t r;
                    r = dq_a.pop_front();
                    chk("err_a", 64'(err_a), 64'(r.e));
                    chk("err_cnt_a", 64'(err_cnt_a), 64'(r.cnt));
                    chk("first_err_a", 64'(first_err_addr_a), 64'(r.fa));
                    chk("done_edge_a", 64'(edge_cnt - t0_a), 64'(r.lat));
                    chk("busy_at_done_a", 64'(busy_a), 64'd0);
                    $display("run A done at edge %0d err=%0d err_cnt=%0h first=%0d",
                             edge_cnt - t0_a, err_a, err_cnt_a, first_err_addr_a);
                end
            end
        end
        done_prev_a <= done_a;
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_b) begin
                if (wq_b.size() == 0) chk("wr_b_unexpected", 64'(wraddr_b), 64'hFFFF);
                else chk("wr_b", 64'({wraddr_b, din_b}), 64'(wq_b.pop_front()));
            end
            if (portb_en_b) begin
                if (rq_b.size() == 0) chk("rd_b_unexpected", 64'(rdaddr_b), 64'hFFFF);
                else chk("rd_b", 64'(rdaddr_b), 64'(rq_b.pop_front()));
            end
            if (done_b && !done_prev_b) begin
                if (dq_b.size() == 0) chk("done_b_unexpected", 64'(done_b), 64'd0);
                else begin
                    res_t r;
                    r = dq_b.pop_front();
                    chk("err_b", 64'(err_b), 64'(r.e));
                    chk("err_cnt_b", 64'(err_cnt_b), 64'(r.cnt));
                    chk("first_err_b", 64'(first_err_addr_b), 64'(r.fa));
                    chk("done_edge_b", 64'(edge_cnt - t0_b), 64'(r.lat));
                    $display("run B done at edge %0d err=%0d err_cnt=%0h first=%0d",
                             edge_cnt - t0_b, err_b, err_cnt_b, first_err_addr_b);
                end
            end
        end
        done_prev_b <= done_b;
    end

    function automatic logic [63:0] outs_a();
        return 64'({wraddr_a, din_a, we_a, porta_en_a, rdaddr_a, portb_en_a,
                    busy_a, done_a, err_a, err_cnt_a, first_err_addr_a});
    endfunction

    function automatic logic [63:0] outs_b();
        return 64'({wraddr_b, din_b, we_b, porta_en_b, rdaddr_b, portb_en_b,
                    busy_b, done_b, err_b, err_cnt_b, first_err_addr_b});
    endfunction

    initial begin
        logic hit;
        #3 rst_n = 0;
        #1;
        chk("reset_outs_a", outs_a(), 64'd0);
        chk("reset_outs_b", outs_b(), 64'd0);
        @(negedge clk);
        #2 rst_n = 1;

        // 1: clean run
        expect_run(0, 32, 1'b0, 16'h0000, 4'd0, 50);
        start_pulse(0, 1'b0);
        wait_done(0, 80);

        // 2: fault on address 5, started from DONE
        fault_a = 1;
        expect_run(0, 32, 1'b1, 16'h0002, 4'd5, 50);
        start_pulse(0, 1'b0);
        wait_done(0, 80);
        fault_a = 0;

        // 5: start in DONE clears errors; stop in FILL and start in SWEEP are ignored
        expect_run(0, 32, 1'b0, 16'h0000, 4'd0, 50);
        start_pulse(0, 1'b0);
        chk("cleared_after_start_a", 64'({err_a, err_cnt_a, first_err_addr_a, busy_a, done_a}),
            64'({1'b0, 16'h0000, 4'd0, 1'b1, 1'b0}));
        repeat (4) @(posedge clk);
        #1 stop_a = 1;
        @(posedge clk);
        #1 stop_a = 0;
        repeat (15) @(posedge clk);
        #1 start_a = 1;
        @(posedge clk);
        #1 start_a = 0;
        wait_done(0, 80);

        // 4: asynchronous reset at wraddr 7, then a fresh run
        expect_run(0, 32, 1'b0, 16'h0000, 4'd0, 50);
        start_pulse(0, 1'b0);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (we_a && wraddr_a == 4'd7) begin hit = 1; break; end
        end
        chk("reached_wraddr7", 64'(hit), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_outs_a", outs_a(), 64'd0);
        wq_a.delete(); rq_a.delete(); dq_a.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1;
        expect_run(0, 32, 1'b0, 16'h0000, 4'd0, 50);
        start_pulse(0, 1'b0);
        wait_done(0, 80);

        // 3: SWEEPS=0 with start+stop together in IDLE, stop on 20th SWEEP cycle
        expect_run(1, 20, 1'b0, 16'h0000, 4'd0, 38);
        start_pulse(1, 1'b1);
        repeat (35) @(posedge clk);
        #1 stop_b = 1;
        @(posedge clk);
        #1 stop_b = 0;
        wait_done(1, 20);
        repeat (3) @(negedge clk);

        // 6: saturation, every read corrupted for 70000 SWEEP cycles
        corrupt_b = 1;
        expect_run(1, 70000, 1'b1, 16'hFFFF, 4'd0, 70018);
        start_pulse(1, 1'b0);
        repeat (70015) @(posedge clk);
        #1 stop_b = 1;
        @(posedge clk);
        #1 stop_b = 0;
        wait_done(1, 20);
        corrupt_b = 0;

        repeat (2) @(negedge clk);
        chk("wq_a_empty", 64'(wq_a.size()), 64'd0);
        chk("rq_a_empty", 64'(rq_a.size()), 64'd0);
        chk("dq_a_empty", 64'(dq_a.size()), 64'd0);
        chk("wq_b_empty", 64'(wq_b.size()), 64'd0);
        chk("rq_b_empty", 64'(rq_b.size()), 64'd0);
        chk("dq_b_empty", 64'(dq_b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
